// File: rtl/ask_symbol_source.sv
// 4-ASK stimulus source: PRBS15 -> Gray-mapped 2-bit symbols -> signed levels, upsampled x4.
// Define ASK_SRC_ZERO_STUFF_EN for impulse upsampling; the default holds each level for 4 samples.
module ask_symbol_source #(
    parameter int WIDTH         = 18,
    parameter int LEVEL_A       = 32768,
    parameter int FLUSH_SAMPLES = 96,
    parameter int CNT_W         = 16
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic                    sam_clk_en,
    input  logic                    sym_clk_en,
    input  logic                    enable,
    input  logic                    load_seed,
    input  logic [14:0]             seed,
    output logic signed [WIDTH-1:0] x_out,
    output logic [1:0]              sym_out,
    output logic                    sym_valid,
    output logic                    busy,
    output logic [CNT_W-1:0]        sym_count
);

    localparam int FW = $clog2(FLUSH_SAMPLES + 1);
    localparam logic signed [WIDTH-1:0] LVL_1 = WIDTH'(LEVEL_A);
    localparam logic signed [WIDTH-1:0] LVL_3 = WIDTH'(3 * LEVEL_A);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                  state, state_nxt;
    logic [14:0]             lfsr, lfsr_nxt, lfsr_adv;
    logic [FW-1:0]           flush_cnt, flush_nxt;
    logic signed [WIDTH-1:0] x_nxt, level;
    logic [1:0]              sym_new, sym_nxt;
    logic                    valid_nxt;
    logic [CNT_W-1:0]        count_nxt;
    logic                    sym_edge, emit;

    // A symbol boundary is only honoured when it coincides with a sample tick.
    assign sym_edge = sam_clk_en & sym_clk_en;
    assign busy     = (state != IDLE);

    // Two Fibonacci steps per symbol; the first new bit becomes b1, the second b0.
    always_comb begin
        sym_new  = {lfsr[14] ^ lfsr[13], lfsr[13] ^ lfsr[12]};
        lfsr_adv = {lfsr[12:0], sym_new};
        case (sym_new)
            2'b00:   level = -LVL_3;
            2'b01:   level = -LVL_1;
            2'b11:   level = LVL_1;
            default: level = LVL_3;
        endcase
    end

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        lfsr_nxt  = lfsr;
        x_nxt     = x_out;
        sym_nxt   = sym_out;
        valid_nxt = 1'b0;
        count_nxt = sym_count;
        flush_nxt = flush_cnt;
        emit      = 1'b0;

        case (state)
            IDLE: begin
                x_nxt = '0;
                if (sym_edge && enable) begin
                    emit      = 1'b1;
                    state_nxt = RUN;
                end else if (load_seed) begin
                    lfsr_nxt = (seed == 15'd0) ? 15'h0001 : seed;
                end
            end
            RUN: begin
                if (sym_edge) begin
                    if (enable) begin
                        emit = 1'b1;
                    end else begin
                        x_nxt     = '0;
                        state_nxt = FLUSH;
                        flush_nxt = FW'(1);
                    end
                end
`ifdef ASK_SRC_ZERO_STUFF_EN
                else if (sam_clk_en) begin
                    x_nxt = '0;
                end
`endif
            end
            FLUSH: begin
                x_nxt = '0;
                if (sym_edge && enable) begin
                    emit      = 1'b1;
                    state_nxt = RUN;
                    flush_nxt = '0;
                end else if (sam_clk_en) begin
                    // The edge that entered FLUSH was zero sample 1, so this edge is the last one.
                    if (flush_cnt >= FW'(FLUSH_SAMPLES - 1)) begin
                        state_nxt = IDLE;
                        flush_nxt = '0;
                    end else begin
                        flush_nxt = flush_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (emit) begin
            lfsr_nxt  = lfsr_adv;
            x_nxt     = level;
            sym_nxt   = sym_new;
            valid_nxt = 1'b1;
            count_nxt = sym_count + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them sample the same pre-edge values.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            lfsr      <= 15'h0001;
            x_out     <= '0;
            sym_out   <= '0;
            sym_valid <= 1'b0;
            sym_count <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            lfsr      <= lfsr_nxt;
            x_out     <= x_nxt;
            sym_out   <= sym_nxt;
            sym_valid <= valid_nxt;
            sym_count <= count_nxt;
            flush_cnt <= flush_nxt;
        end
    end

endmodule
